// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Owns the register file's single write port and merges two result sources
// into one registered write per cycle. Single-cycle pipeline writebacks always
// win the port; long-latency results (multiply/divide, slow loads) wait in a
// small in-order FIFO and drain in idle write slots. A per-register busy
// scoreboard tells decode which registers still have a long-latency write
// outstanding.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   p_wr/p_addr/p_data    pipeline writeback, never back-pressured
//   l_valid/l_ready       long-latency result handshake into the FIFO
//   l_addr/l_data         long-latency destination register and result
//   rsv_en/rsv_addr       reserve a register when a long-latency op issues
//   chk_addr1/2           decode source registers to query
//   chk_busy1/2           queried register has an outstanding long write
//   wr/addr3/data3        registered register-file write port
//   fifo_cnt              FIFO occupancy
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     p_wr,
   input  logic [AW-1:0]            p_addr,
   input  logic [DW-1:0]            p_data,
   input  logic                     l_valid,
   output logic                     l_ready,
   input  logic [AW-1:0]            l_addr,
   input  logic [DW-1:0]            l_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   input  logic [AW-1:0]            chk_addr1,
   input  logic [AW-1:0]            chk_addr2,
   output logic                     chk_busy1,
   output logic                     chk_busy2,
   output logic                     wr,
   output logic [AW-1:0]            addr3,
   output logic [DW-1:0]            data3,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int          PW   = $clog2(DEPTH);
   localparam int          EW   = AW + DW;
   localparam int          NREG = 1 << AW;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   addr3_q, addr3_d;
   logic [DW-1:0]   data3_q, data3_d;

   logic            pipe_busy;
   logic            push;
   logic            pop;
   logic [AW-1:0]   head_addr;
   logic [DW-1:0]   head_data;

   // A pipeline write to register 0 is a no-op, so it leaves the slot free.
   assign pipe_busy = p_wr && (p_addr != '0);

   // Depends only on occupancy, never on the pop decision, so there is no
   // combinational path from p_wr to l_ready.
   assign l_ready   = reset && (cnt_q < FULL);
   assign push      = l_valid && l_ready;
   assign pop       = !pipe_busy && (cnt_q != '0);

   assign {head_addr, head_data} = mem_q[rd_ptr_q];

   // NOTE: combinational blocks use blocking assignments and give every
   // signal a default first, so no latch is inferred on any path.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Pointers are PW bits wide and DEPTH is a power of two, so the
      // increment wraps modulo DEPTH on its own.
      if (push) begin
         mem_d[wr_ptr_q] = {l_addr, l_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Clear on pop first, then set on reservation: a same-cycle set wins.
   // Register 0 is forced idle regardless of either.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_addr] = 1'b0;
      end
      if (rsv_en) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Output register: pipeline first, then FIFO head. An address-0 FIFO
   // entry is consumed with wr=0. On an idle slot addr3/data3 hold.
   always_comb begin
      wr_d    = 1'b0;
      addr3_d = addr3_q;
      data3_d = data3_q;
      if (pipe_busy) begin
         wr_d    = 1'b1;
         addr3_d = p_addr;
         data3_d = p_data;
      end else if (pop) begin
         wr_d    = (head_addr != '0);
         addr3_d = head_addr;
         data3_d = head_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         wr_q     <= 1'b0;
         addr3_q  <= '0;
         data3_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         wr_q     <= wr_d;
         addr3_q  <= addr3_d;
         data3_q  <= data3_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; a slot is only read
   // after it has been written, which the reset pointers and count guarantee.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign chk_busy1 = (chk_addr1 != '0) && busy_q[chk_addr1];
   assign chk_busy2 = (chk_addr2 != '0) && busy_q[chk_addr2];
   assign wr        = wr_q;
   assign addr3     = addr3_q;
   assign data3     = data3_q;
   assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Self-checking bench for wb_write_arbiter. Each cycle task cyc() drives the
// inputs and, from a queue model of the long-latency FIFO, pushes the write
// the arbiter should present into exp_q. A negedge monitor pops exp_q on
// every wr=1 and compares address and data. Scenario tasks add inline checks
// of wr, fifo_cnt, l_ready and the busy outputs.
// -----------------------------------------------------------------------------
module tb_wb_write_arbiter;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk;
   logic          reset;
   logic          p_wr;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic          l_valid;
   logic          l_ready;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_data;
   logic          rsv_en;
   logic [AW-1:0] rsv_addr;
   logic [AW-1:0] chk_addr1;
   logic [AW-1:0] chk_addr2;
   logic          chk_busy1;
   logic          chk_busy2;
   logic          wr;
   logic [AW-1:0] addr3;
   logic [DW-1:0] data3;
   logic [2:0]    fifo_cnt;

   int   total = 0;
   int   bad   = 0;
   ent_t exp_q[$];
   ent_t m_fifo[$];
   ent_t sb_e;
   bit   last_acc;

   wb_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .p_wr      (p_wr),
      .p_addr    (p_addr),
      .p_data    (p_data),
      .l_valid   (l_valid),
      .l_ready   (l_ready),
      .l_addr    (l_addr),
      .l_data    (l_data),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .chk_busy1 (chk_busy1),
      .chk_busy2 (chk_busy2),
      .wr        (wr),
      .addr3     (addr3),
      .data3     (data3),
      .fifo_cnt  (fifo_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard consumer: every presented write must be the next expected one.
   always @(negedge clk) begin
      if (reset === 1'b1 && wr === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got addr=%0d data=%h want no write", addr3, data3);
         end else begin
            sb_e = exp_q.pop_front();
            if ({addr3, data3} !== sb_e) begin
               bad++;
               $display("FAIL sb_write: got addr=%0d data=%h want addr=%0d data=%h",
                        addr3, data3, sb_e.a, sb_e.d);
            end
         end
      end
   end

   // Drive one cycle's inputs (called at a negedge), record what the arbiter
   // must present after the coming edge, then wait for the next negedge.
   task automatic cyc(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic re, input logic [AW-1:0] ra);
      ent_t e;
      p_wr     = pw;
      p_addr   = pa;
      p_data   = pd;
      l_valid  = lv;
      l_addr   = la;
      l_data   = ld;
      rsv_en   = re;
      rsv_addr = ra;
      last_acc = lv && (m_fifo.size() < DEPTH);
      if (pw && pa != '0) begin
         exp_q.push_back(ent_t'{a: pa, d: pd});
      end else if (m_fifo.size() > 0) begin
         e = m_fifo.pop_front();
         if (e.a != '0) exp_q.push_back(e);
      end
      if (last_acc) m_fifo.push_back(ent_t'{a: la, d: ld});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
      l_valid = 1'b0; l_addr = '0; l_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      chk_addr1 = '0; chk_addr2 = '0;
      @(negedge clk);
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %0b want 0", wr); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); end
      total++; if (l_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", l_ready); end
      reset = 1'b1;
      idle(1);
      total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %0b want 1", l_ready); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL idle_cnt: got %0d want 0", fifo_cnt); end
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL idle_wr: got %0b want 0", wr); end
      total++; if (addr3 !== 5'd0) begin bad++; $display("FAIL idle_addr3: got %0d want 0", addr3); end
      total++; if (data3 !== 32'd0) begin bad++; $display("FAIL idle_data3: got %h want 0", data3); end
   endtask

   task automatic test_pipeline();
      cyc(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
      total++; if (wr !== 1'b1) begin bad++; $display("FAIL pipe_wr: got %0b want 1", wr); end
      total++; if (addr3 !== 5'd7) begin bad++; $display("FAIL pipe_addr3: got %0d want 7", addr3); end
      total++; if (data3 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_data3: got %h want deadbeef", data3); end
      idle(1);
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL pipe_wr_off: got %0b want 0", wr); end
      total++; if (addr3 !== 5'd7) begin bad++; $display("FAIL pipe_addr3_hold: got %0d want 7", addr3); end
      total++; if (data3 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_data3_hold: got %h want deadbeef", data3); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3];
      addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd31;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, addrs[i], 32'h1000_0000 + 32'(i), 1'b0, '0, '0, 1'b0, '0);
         total++; if (wr !== 1'b1) begin bad++; $display("FAIL b2b_wr%0d: got %0b want 1", i, wr); end
         total++; if (addr3 !== addrs[i]) begin bad++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, addr3, addrs[i]); end
      end
      idle(2);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_long_idle();
      chk_addr1 = 5'd9;
      chk_addr2 = 5'd9;
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
      total++; if (chk_busy1 !== 1'b1) begin bad++; $display("FAIL rsv_busy1: got %0b want 1", chk_busy1); end
      total++; if (chk_busy2 !== 1'b1) begin bad++; $display("FAIL rsv_busy2: got %0b want 1", chk_busy2); end
      total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL long_ready: got %0b want 1", l_ready); end
      cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_1234, 1'b0, '0);
      total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL long_cnt_e0: got %0d want 1", fifo_cnt); end
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL long_no_bypass: got %0b want 0", wr); end
      total++; if (chk_busy1 !== 1'b1) begin bad++; $display("FAIL long_busy_e0: got %0b want 1", chk_busy1); end
      idle(1);
      total++; if (wr !== 1'b1) begin bad++; $display("FAIL long_wr_e1: got %0b want 1", wr); end
      total++; if (addr3 !== 5'd9) begin bad++; $display("FAIL long_addr3: got %0d want 9", addr3); end
      total++; if (data3 !== 32'h0000_1234) begin bad++; $display("FAIL long_data3: got %h want 1234", data3); end
      total++; if (chk_busy1 !== 1'b0) begin bad++; $display("FAIL long_busy_clr: got %0b want 0", chk_busy1); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL long_cnt_e1: got %0d want 0", fifo_cnt); end
      idle(1);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL long_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_contention_full();
      int  j;
      bit  pw;
      j = 0;
      for (int c = 0; c < 12; c++) begin
         pw = (c < 6);
         cyc(pw, 5'd3, 32'hA000_0000 + 32'(c), (j < 5), 5'(10 + j), 32'hB000_0000 + 32'(j), 1'b0, '0);
         if (last_acc) j++;
         if (c == 3 || c == 5) begin
            total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL full_cnt_c%0d: got %0d want 4", c, fifo_cnt); end
            total++; if (l_ready !== 1'b0) begin bad++; $display("FAIL full_ready_c%0d: got %0b want 0", c, l_ready); end
         end
         if (c == 6 || c == 7) begin
            total++; if (fifo_cnt !== 3'd3) begin bad++; $display("FAIL drain_cnt_c%0d: got %0d want 3", c, fifo_cnt); end
            total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_c%0d: got %0b want 1", c, l_ready); end
         end
      end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL cont_cnt_end: got %0d want 0", fifo_cnt); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_same_cycle();
      chk_addr1 = 5'd5;
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
      cyc(1'b1, 5'd4, 32'h4400_0001, 1'b1, 5'd5, 32'h0000_0055, 1'b0, '0);
      cyc(1'b1, 5'd4, 32'h4400_0002, 1'b1, 5'd6, 32'h0000_0066, 1'b0, '0);
      total++; if (fifo_cnt !== 3'd2) begin bad++; $display("FAIL same_cnt_pre: got %0d want 2", fifo_cnt); end
      // Pop of the register-5 entry, a push and a register-5 reservation together.
      cyc(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd5);
      total++; if (fifo_cnt !== 3'd2) begin bad++; $display("FAIL same_cnt_hold: got %0d want 2", fifo_cnt); end
      total++; if (wr !== 1'b1) begin bad++; $display("FAIL same_wr: got %0b want 1", wr); end
      total++; if (addr3 !== 5'd5) begin bad++; $display("FAIL same_addr3: got %0d want 5", addr3); end
      total++; if (chk_busy1 !== 1'b1) begin bad++; $display("FAIL same_set_wins: got %0b want 1", chk_busy1); end
      idle(3);
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL same_cnt_end: got %0d want 0", fifo_cnt); end
      total++; if (chk_busy1 !== 1'b1) begin bad++; $display("FAIL same_busy_kept: got %0b want 1", chk_busy1); end
      cyc(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_005A, 1'b0, '0);
      idle(1);
      total++; if (chk_busy1 !== 1'b0) begin bad++; $display("FAIL same_busy_clr: got %0b want 0", chk_busy1); end
      idle(1);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL same_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_addr0();
      cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, '0);
      total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL a0_cnt_push: got %0d want 1", fifo_cnt); end
      idle(1);
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL a0_wr: got %0b want 0", wr); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL a0_cnt_pop: got %0d want 0", fifo_cnt); end
      total++; if (addr3 !== 5'd0) begin bad++; $display("FAIL a0_addr3: got %0d want 0", addr3); end
      total++; if (data3 !== 32'h0000_FFFF) begin bad++; $display("FAIL a0_data3: got %h want ffff", data3); end
      cyc(1'b0, '0, '0, 1'b1, 5'd12, 32'h0000_C0C0, 1'b0, '0);
      cyc(1'b1, 5'd0, 32'h0000_0BAD, 1'b0, '0, '0, 1'b0, '0);
      total++; if (wr !== 1'b1) begin bad++; $display("FAIL p0_wr: got %0b want 1", wr); end
      total++; if (addr3 !== 5'd12) begin bad++; $display("FAIL p0_addr3: got %0d want 12", addr3); end
      total++; if (data3 !== 32'h0000_C0C0) begin bad++; $display("FAIL p0_data3: got %h want c0c0", data3); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL p0_cnt: got %0d want 0", fifo_cnt); end
      chk_addr1 = 5'd0;
      chk_addr2 = 5'd0;
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
      total++; if (chk_busy1 !== 1'b0) begin bad++; $display("FAIL r0_busy1: got %0b want 0", chk_busy1); end
      total++; if (chk_busy2 !== 1'b0) begin bad++; $display("FAIL r0_busy2: got %0b want 0", chk_busy2); end
      idle(1);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL a0_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_random_mix();
      logic pw;
      logic lv;
      for (int i = 0; i < 60; i++) begin
         total++;
         if (fifo_cnt !== 3'(m_fifo.size())) begin
            bad++; $display("FAIL rnd_cnt%0d: got %0d want %0d", i, fifo_cnt, m_fifo.size());
         end
         total++;
         if (l_ready !== (m_fifo.size() < DEPTH)) begin
            bad++; $display("FAIL rnd_ready%0d: got %0b want %0b", i, l_ready, (m_fifo.size() < DEPTH));
         end
         pw = ($urandom_range(0, 1) == 1);
         lv = ($urandom_range(0, 9) < 6);
         cyc(pw, 5'($urandom_range(0, 31)), $urandom, lv, 5'($urandom_range(0, 31)), $urandom, 1'b0, '0);
      end
      idle(6);
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL rnd_cnt_end: got %0d want 0", fifo_cnt); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_drain();
      chk_addr1 = 5'd8;
      cyc(1'b1, 5'd4, 32'h4444_0001, 1'b1, 5'd8, 32'h8888_0001, 1'b1, 5'd8);
      cyc(1'b1, 5'd4, 32'h4444_0002, 1'b1, 5'd9, 32'h9999_0001, 1'b0, '0);
      total++; if (fifo_cnt !== 3'd2) begin bad++; $display("FAIL mid_cnt_pre: got %0d want 2", fifo_cnt); end
      total++; if (chk_busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %0b want 1", chk_busy1); end
      #2;
      reset = 1'b0;
      p_wr = 1'b0; l_valid = 1'b0; rsv_en = 1'b0;
      #1;
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL mid_cnt_async: got %0d want 0", fifo_cnt); end
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL mid_wr_async: got %0b want 0", wr); end
      total++; if (l_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_async: got %0b want 0", l_ready); end
      total++; if (chk_busy1 !== 1'b0) begin bad++; $display("FAIL mid_busy_async: got %0b want 0", chk_busy1); end
      total++; if (addr3 !== 5'd0) begin bad++; $display("FAIL mid_addr3_async: got %0d want 0", addr3); end
      total++; if (data3 !== 32'd0) begin bad++; $display("FAIL mid_data3_async: got %h want 0", data3); end
      exp_q.delete();
      m_fifo.delete();
      @(negedge clk);
      reset = 1'b1;
      idle(3);
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL mid_wr_after: got %0b want 0", wr); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL mid_cnt_after: got %0d want 0", fifo_cnt); end
      total++; if (chk_busy1 !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %0b want 0", chk_busy1); end
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_back_to_back();
      test_long_idle();
      test_contention_full();
      test_same_cycle();
      test_addr0();
      test_random_mix();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side companion to the register file: owns its single write port (wr/addr3/data3) and merges two result sources into one registered write per cycle. The single-cycle pipeline writeback always wins the port. Long-latency results (multiply/divide, slow loads) are queued in a small FIFO and drained in idle write slots. A per-register busy scoreboard lets decode stall on registers whose long-latency result is still outstanding.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries; power of 2, ≥2
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- p_wr  in  1  pipeline writeback request, never back-pressured
- p_addr  in  AW  pipeline destination register
- p_data  in  DW  pipeline result
- l_valid  in  1  long-latency result valid
- l_ready  out  1  FIFO can accept (count < DEPTH)
- l_addr  in  AW  long-latency destination register
- l_data  in  DW  long-latency result
- rsv_en  in  1  reserve register at issue of a long-latency op
- rsv_addr  in  AW  register to reserve
- chk_addr1, chk_addr2  in  AW  decode source registers to query
- chk_busy1, chk_busy2  out  1  queried register has an outstanding long-latency write (combinational)
- wr  out  1  register-file write enable (registered)
- addr3  out  AW  register-file write address (registered)
- data3  out  DW  register-file write data (registered)
- fifo_cnt  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: at a rising edge with l_valid && l_ready, {l_addr, l_data} enters the FIFO tail.
- l_ready = (count < DEPTH) && reset high. No combinational path from the pop decision.
- Pipeline slot busy when p_wr && p_addr != 0. A p_wr to address 0 counts as idle.
- Each edge, the output register loads exactly one of:
  - pipeline busy: {1, p_addr, p_data}.
  - else FIFO non-empty: pop head and load {head_addr != 0, head_addr, head_data}. An address-0 entry is popped and discarded with wr=0.
  - else: wr=0. addr3/data3 hold their previous values.
- FIFO is in-order; pointers wrap modulo DEPTH. Simultaneous push and pop is legal at any occupancy below DEPTH. When full, push is blocked and pop proceeds normally.
- Scoreboard: 31 busy bits (register 0 is never busy).
  - Set on rsv_en with rsv_addr != 0.
  - Cleared at the edge where a popped FIFO entry with that address loads the output register.
  - Set and clear of the same register in the same cycle: set wins.
- chk_busyN = busy[chk_addrN]; 0 when chk_addrN == 0.
- A pipeline write to a busy register does not touch its busy bit. Decode must stall write-after-write on busy registers; the arbiter does not detect this.
- Starvation is allowed: continuous pipeline writes hold the FIFO, and l_ready then drops when the FIFO is full.

## Timing
- Reset asserted (asynchronous): wr=0, addr3=0, data3=0, FIFO empty, fifo_cnt=0, all busy bits 0, l_ready=0.
  - A reset mid-drain discards queued entries and reservations.
  - First accept is possible at the first edge after reset deasserts.
- Pipeline write: p_wr sampled at edge E; wr/addr3/data3 valid from E until E+1. The register file commits at edge E+1.
- Long-latency write, best case: push at E0 → head valid after E0 → pop and output load at E1 → register-file commit at E2.
  - No empty-FIFO bypass.
  - Each cycle of pipeline activity adds one cycle of delay.
- Busy bit changes become visible on chk_busy the cycle after the setting or clearing edge.
  - A result popped at E1 clears its busy bit after E1, the same cycle its write is presented.
  - Decode relies on the register file's same-cycle write-to-read bypass for that cycle.
- fifo_cnt updates at each edge: +1 on push only, −1 on pop only, unchanged on both.

## Test plan
- Reset then idle: wr=0, addr3=0, data3=0, l_ready=1, fifo_cnt=0. Assert reset with 2 entries queued → fifo_cnt=0 and wr=0 immediately, before any clock edge.
- Pipeline only: p_wr=1, p_addr=7, p_data=0xDEADBEEF at edge E → wr=1, addr3=7, data3=0xDEADBEEF after E; p_wr=0 at E+1 → wr=0 after E+1.
- Long result during idle: rsv_en with addr 9 → chk_busy1=1 for chk_addr1=9. Push {9, 0x1234} at E0 → wr=1, addr3=9, data3=0x1234 after E1; chk_busy1=0 after E1.
- Contention and full: p_wr=1 (addr 3) for 6 cycles while pushing 5 long results → l_ready=0 once fifo_cnt=4 (5th push held). After p_wr drops, 4 entries drain on consecutive cycles in push order, then the 5th.
- Same-cycle push, pop and reservation: fifo_cnt=2, pop and push in one cycle → fifo_cnt stays 2. rsv_en for register 5 in the cycle a register-5 entry pops → busy[5] stays 1.
- Address 0: push {0, 0xFFFF} → popped with wr=0 and fifo_cnt decrements. p_wr with p_addr=0 leaves the slot free, so a queued FIFO entry drains in that cycle. rsv_en with rsv_addr=0 → chk_busy stays 0.
